telemetry_framer: RTL and testbench
===================================

# telemetry_framer

- Parametrised successor to the fixed gyro-axis UART byte sequencer.
- Snapshots NUM_CH samples of CH_WIDTH bits and serialises them into a framed byte stream: sync byte, sequence number, little-endian payload, optional checksum.
- Sits between sensor front-ends (PmodGYRO axis outputs or similar) and UART_TX, handing over one byte per valid/ready transfer.

## Interface
Parameters:
- NUM_CH, 3, number of sample channels (1..16)
- CH_WIDTH, 16, bits per channel (1..32); BYTES_PER_CH = ceil(CH_WIDTH/8)
- SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ch_data  in  NUM_CH*CH_WIDTH  channel samples; channel 0 in the LSBs
- sample_valid  in  1  snapshot request
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data holds a byte to send
- tx_ready  in  1  transmitter accepts the byte this cycle
- busy  out  1  frame in progress (state != IDLE)
- overrun  out  1  one-cycle pulse: sample_valid dropped
- seq_num  out  8  sequence number of the next frame to start

## Operation
- States: IDLE, SYNC, SEQ, PAYLOAD, CSUM.
- IDLE + sample_valid:
  - latch ch_data into the snapshot register
  - go to SYNC with tx_data=SYNC_BYTE, tx_valid=1
- Transfer: tx_valid && tx_ready on a rising edge.
- On each transfer, the next byte is loaded in the same edge, so back-to-back bytes are possible.
- Byte order:
  - SYNC_BYTE
  - seq_num
  - payload, channel 0 first, each channel least-significant byte first
  - CSUM (if enabled)
- Payload length: NUM_CH*BYTES_PER_CH bytes.
- Unused upper bits of a channel's top byte are sent as 0.
- Byte index counter: ceil(log2(NUM_CH*BYTES_PER_CH+1)) bits; it wraps to 0 at the end of PAYLOAD.
- Transfer of the final byte:
  - return to IDLE, tx_valid=0
  - seq_num increments modulo 256 (255 -> 0)
- sample_valid outside IDLE, including the final-transfer cycle:
  - snapshot is unchanged; overrun pulses the following cycle
- tx_data and tx_valid stay constant while tx_valid=1 and tx_ready=0.
- ch_data changes after the snapshot do not affect the frame in progress.

## Timing
- Reset values: tx_data=0, tx_valid=0, busy=0, overrun=0, seq_num=0; state IDLE, snapshot and checksum cleared.
- Reset is asynchronous; outputs clear immediately, including mid-frame. The partial frame is abandoned and not resumed.
- Latency: sample_valid sampled at edge N -> tx_valid=1 and busy=1 after edge N.
- Throughput with tx_ready held high: one byte per cycle; frame length L = 2+payload(+1).
- busy falls on the edge that transfers the final byte.
- tx_ready while tx_valid=0 is ignored.

## Configuration
- TELEMETRY_FRAMER_CHECKSUM_EN defined:
  - CSUM state present
  - appended byte = modulo-256 sum of seq_num and all payload bytes (sync excluded)
  - accumulator cleared on frame start
- Not defined:
  - CSUM state and accumulator omitted
  - frame ends after the last payload byte
  - final transfer is the last payload byte

## Test plan
- Checksum on, NUM_CH=3, CH_WIDTH=16, ch_data={16'h00FF,16'hABCD,16'h1234}, one sample_valid pulse, tx_ready=1 -> bytes A5 00 34 12 CD AB FF 00 BD on 9 consecutive cycles; seq_num=1, busy=0 afterwards.
- Same config, tx_ready toggling 1-0-0-1 -> each byte held stable while tx_ready=0; byte order unchanged; no duplicates or losses.
- Second sample_valid during PAYLOAD and in the final-transfer cycle -> two overrun pulses, frame bytes unchanged, no new frame starts.
- CH_WIDTH=12, NUM_CH=1, sample 12'hFAB, checksum off -> bytes A5 00 AB 0F.
- 256 back-to-back frames -> seq byte runs 00..FF and wraps to 00.
- Reset asserted mid-PAYLOAD -> tx_valid=0, seq_num=0 immediately; next frame begins with A5 00.

Source files
------------

// File: rtl/telemetry_framer.sv
// telemetry_framer
//   Snapshots NUM_CH samples of CH_WIDTH bits and serialises them into a
//   framed byte stream for a UART transmitter. Each frame is sent as:
//     SYNC_BYTE, seq_num, payload (channel 0 first, each channel LSB first),
//     then an optional checksum byte.
//   One byte is handed over per tx_valid/tx_ready transfer. The next byte is
//   loaded on the same edge as the transfer, so bytes can go out back to back.
//
// Build option:
//   TELEMETRY_FRAMER_CHECKSUM_EN - when defined, the frame gains a trailing
//   checksum byte. It is the modulo-256 sum of seq_num and all payload bytes.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   ch_data       NUM_CH*CH_WIDTH channel samples, channel 0 in the LSBs
//   sample_valid  snapshot request, honoured only while idle
//   tx_data       byte offered to the UART transmitter
//   tx_valid      tx_data holds a byte to send
//   tx_ready      transmitter accepts the byte this cycle
//   busy          a frame is in progress
//   overrun       one-cycle pulse, a sample_valid was dropped
//   seq_num       sequence number of the next frame to start
`timescale 1ns/1ps

module telemetry_framer #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned CH_WIDTH  = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  input  logic                       sample_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       overrun,
  output logic [7:0]                 seq_num
);

  localparam int unsigned BYTES_PER_CH = (CH_WIDTH + 7) / 8;
  localparam int unsigned PAY_LEN      = NUM_CH * BYTES_PER_CH;
  localparam int unsigned IDX_W        = $clog2(PAY_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
    PAYLOAD,
    CSUM
`else
    PAYLOAD
`endif
  } state_t;

  state_t                 state_q;
  logic [PAY_LEN*8-1:0]   snap_q;
  logic [PAY_LEN*8-1:0]   snap_d;
  logic [IDX_W-1:0]       idx_q;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic [7:0]             seq_num_q;
  logic [7:0]             pay_byte;
  logic                   xfer;
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  assign xfer = tx_valid_q & tx_ready;

  // Every channel is widened to a whole number of bytes. The padding bits
  // stay zero, so a channel's top byte carries zeros above CH_WIDTH.
  always_comb begin
    snap_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      snap_d[c*BYTES_PER_CH*8 +: CH_WIDTH] = ch_data[c*CH_WIDTH +: CH_WIDTH];
    end
  end

  // idx_q is the index of the next payload byte to load. The value PAY_LEN
  // marks that the last payload byte is already on tx_data.
  always_comb begin
    pay_byte = '0;
    for (int unsigned k = 0; k < PAY_LEN; k++) begin
      if (idx_q == IDX_W'(k)) begin
        pay_byte = snap_q[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      seq_num_q  <= '0;
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      // This includes the final-transfer cycle, because state_q is not idle yet.
      overrun_q <= sample_valid && (state_q != IDLE);

      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            snap_q     <= snap_d;
            idx_q      <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SYNC;
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end

        SYNC: begin
          if (xfer) begin
            tx_data_q <= seq_num_q;
            state_q   <= SEQ;
          end
        end

        SEQ: begin
          if (xfer) begin
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
            csum_q    <= csum_q + tx_data_q;
`endif
            tx_data_q <= pay_byte;
            idx_q     <= idx_q + 1'b1;
            state_q   <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (xfer) begin
            if (idx_q == IDX_W'(PAY_LEN)) begin
              idx_q <= '0;
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
              // The last payload byte is folded straight into the byte being
              // loaded, so the checksum needs no extra cycle.
              tx_data_q <= csum_q + tx_data_q;
              csum_q    <= csum_q + tx_data_q;
              state_q   <= CSUM;
`else
              tx_data_q  <= '0;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              seq_num_q  <= seq_num_q + 8'd1;
              state_q    <= IDLE;
`endif
            end else begin
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
              csum_q    <= csum_q + tx_data_q;
`endif
              tx_data_q <= pay_byte;
              idx_q     <= idx_q + 1'b1;
            end
          end
        end

`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            seq_num_q  <= seq_num_q + 8'd1;
            state_q    <= IDLE;
          end
        end
`endif

        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign seq_num  = seq_num_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// tb_telemetry_framer
//   Directed testbench for telemetry_framer. The main instance uses
//   NUM_CH=3 and CH_WIDTH=16. A second instance uses NUM_CH=1 and
//   CH_WIDTH=12 to cover the zero-padded top byte.
//   Expected frames follow TELEMETRY_FRAMER_CHECKSUM_EN in the same way as
//   the design does.
`timescale 1ns/1ps

module tb_telemetry_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] ch_data;
  logic        sample_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;
  logic [7:0]  seq_num;

  logic [11:0] ch12;
  logic        sv12;
  logic [7:0]  txd12;
  logic        txv12;
  logic        rdy12;
  logic        busy12;
  logic        ovr12;
  logic [7:0]  seq12;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [3:0]  ready_pat = 4'b1001;

  always #5 clk = ~clk;

  telemetry_framer #(.NUM_CH(3), .CH_WIDTH(16), .SYNC_BYTE(8'hA5)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .ch_data      (ch_data),
    .sample_valid (sample_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .overrun      (overrun),
    .seq_num      (seq_num)
  );

  telemetry_framer #(.NUM_CH(1), .CH_WIDTH(12), .SYNC_BYTE(8'hA5)) u_dut12 (
    .clk          (clk),
    .reset        (reset),
    .ch_data      (ch12),
    .sample_valid (sv12),
    .tx_data      (txd12),
    .tx_valid     (txv12),
    .tx_ready     (rdy12),
    .busy         (busy12),
    .overrun      (ovr12),
    .seq_num      (seq12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame for the 3x16 instance: A5, seq, six payload bytes, and a
  // checksum byte when the checksum option is built in.
  task automatic build_exp(input logic [7:0] seq, input logic [47:0] chd);
    logic [7:0] b;
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
    logic [7:0] sum;
    sum = seq;
`endif
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    for (int k = 0; k < 6; k++) begin
      b = chd[k*8 +: 8];
      exp_q.push_back(b);
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
      sum = sum + b;
`endif
    end
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic start_frame();
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  // Called 1ns after the frame-start edge. Transfers and checks every byte
  // of exp_q. toggle makes tx_ready follow 1-0-0-1. ovr fires extra
  // sample_valid pulses during the payload and in the final-transfer cycle.
  task automatic collect(input bit toggle, input bit ovr);
    int got;
    int cyc;
    int n;
    bit prev_sv;
    n = exp_q.size();
    got = 0;
    cyc = 0;
    prev_sv = 1'b0;
    while (got < n && cyc < 200) begin
      chk("tx_valid", tx_valid, 1);
      chk("busy", busy, 1);
      chk("overrun", overrun, prev_sv);
      chk($sformatf("byte%0d", got), tx_data, exp_q[got]);
      tx_ready     = toggle ? ready_pat[cyc % 4] : 1'b1;
      sample_valid = ovr && tx_ready && (got == 4 || got == n - 1);
      prev_sv      = sample_valid;
      if (tx_ready) got++;
      cyc++;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    chk("frame_len", got, n);
    chk("overrun_end", overrun, prev_sv);
    chk("end_valid", tx_valid, 0);
    chk("end_busy", busy, 0);
    @(posedge clk); #1;
    chk("no_restart", tx_valid, 0);
    chk("overrun_clr", overrun, 0);
  endtask

  initial begin
    logic [7:0] e12[$];
    logic [15:0] a;

    reset = 1'b1;
    ch_data = '0;
    sample_valid = 1'b0;
    tx_ready = 1'b0;
    ch12 = '0;
    sv12 = 1'b0;
    rdy12 = 1'b1;

    // Reset values
    #2 reset = 1'b0;
    #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_seq", seq_num, 0);
    chk("rst_valid12", txv12, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Hand-computed frame with tx_ready held high
    ch_data = {16'h00FF, 16'hABCD, 16'h1234};
    exp_q = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00};
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
    exp_q.push_back(8'hBD);
`endif
    start_frame();
    collect(1'b0, 1'b0);
    chk("seq_after_1", seq_num, 1);

    // tx_ready 1-0-0-1 and ch_data changed after the snapshot
    ch_data = {16'hBEEF, 16'h0102, 16'h8000};
    build_exp(8'h01, ch_data);
    start_frame();
    ch_data = '1;
    collect(1'b1, 1'b0);
    chk("seq_after_2", seq_num, 2);

    // Overrun pulses during the payload and on the final transfer
    ch_data = {16'h7E81, 16'h55AA, 16'hC3C3};
    build_exp(8'h02, ch_data);
    start_frame();
    collect(1'b0, 1'b1);
    chk("seq_after_3", seq_num, 3);

    // 12-bit single channel: the top byte carries zeros above bit 11
    e12 = '{8'hA5, 8'h00, 8'hAB, 8'h0F};
`ifdef TELEMETRY_FRAMER_CHECKSUM_EN
    e12.push_back(8'hBA);
`endif
    ch12 = 12'hFAB;
    sv12 = 1'b1;
    @(posedge clk); #1;
    sv12 = 1'b0;
    foreach (e12[i]) begin
      chk("valid12", txv12, 1);
      chk($sformatf("byte12_%0d", i), txd12, e12[i]);
      @(posedge clk); #1;
    end
    chk("end_valid12", txv12, 0);
    chk("busy12", busy12, 0);
    chk("ovr12", ovr12, 0);
    chk("seq12", seq12, 1);

    // Asynchronous reset in the middle of the payload
    tx_ready = 1'b1;
    ch_data = {16'h1111, 16'h2222, 16'h3333};
    start_frame();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_seq", seq_num, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tx_data", tx_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("no_resume", tx_valid, 0);
    ch_data = {16'h0A0B, 16'h0C0D, 16'h0E0F};
    build_exp(8'h00, ch_data);
    start_frame();
    collect(1'b0, 1'b0);
    chk("seq_after_rst", seq_num, 1);

    // 257 back-to-back frames from reset: seq byte runs 00..FF then 00
    #2 reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 257; i++) begin
      a = 16'(i);
      ch_data = {a ^ 16'h5A5A, ~a, a + 16'h0101};
      build_exp(8'(i), ch_data);
      start_frame();
      collect(1'b0, 1'b0);
    end
    chk("seq_wrap", seq_num, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
